// File: rtl/lane_seg_mul_pkg.sv
// Shared types and helpers for the lane_seg pipelined multiplier.
// Saturating build is selected with LANE_SEG_MUL_SAT_EN.
package lane_seg_mul_pkg;

   localparam int SAT_W = 64;

   typedef struct packed {
      logic valid;
      logic is_signed;
   } stage_hdr_t;

   function automatic int prod_width(input int a, input int b);
      return a + b;
   endfunction

   function automatic logic [SAT_W-1:0] sat_max(input int w, input logic sgn);
      return sgn ? (SAT_W'(1) << (w - 1)) - SAT_W'(1)
                 : (SAT_W'(1) << w) - SAT_W'(1);
   endfunction

   function automatic logic [SAT_W-1:0] sat_min(input int w, input logic sgn);
      return sgn ? -(SAT_W'(1) << (w - 1)) : '0;
   endfunction

endpackage

// File: rtl/lane_seg_mul_narrow.sv
// Last-stage round / shift / narrow for the lane_seg multiplier.
// LANE_SEG_MUL_SAT_EN selects clamping with ovf; otherwise wrap.
module lane_seg_mul_narrow
   import lane_seg_mul_pkg::*;
#(
   parameter int PW    = 22,
   parameter int DW    = 21,
   parameter int SHIFT = 0,
   parameter int ROUND = 0
) (
   input  logic          is_signed,
   input  logic [PW:0]   prod,
   output logic [DW-1:0] dout,
   output logic          ovf
);

   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [PW+1:0] RND =
      (ROUND != 0 && SHIFT > 0) ? ((PW+2)'(1) << RSH) : '0;

   logic [PW+1:0] sum;
   logic [PW+1:0] r;

   // one extra bit so the rounding add never overflows
   always_comb begin
      sum = {is_signed & prod[PW], prod} + RND;
      r   = $signed(sum) >>> SHIFT;
   end

`ifdef LANE_SEG_MUL_SAT_EN
   localparam logic [SAT_W-1:0] UMAX = sat_max(DW, 1'b0);
   localparam logic [SAT_W-1:0] SMAX = sat_max(DW, 1'b1);
   localparam logic [SAT_W-1:0] SMIN = sat_min(DW, 1'b1);

   logic hi_u;
   logic hi_s;

   // clamp to the output range when the shifted value does not fit
   always_comb begin
      hi_u = |r[PW+1:DW];
      hi_s = ~(&r[PW+1:DW-1]) & (|r[PW+1:DW-1]);
      ovf  = is_signed ? hi_s : hi_u;
      dout = r[DW-1:0];
      if (ovf) begin
         if (!is_signed)   dout = UMAX[DW-1:0];
         else if (r[PW+1]) dout = SMIN[DW-1:0];
         else              dout = SMAX[DW-1:0];
      end
   end
`else
   logic unused_hi;

   assign unused_hi = ^r[PW+1:DW];
   assign dout      = r[DW-1:0];
   assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/lane_seg_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready backpressure.
// LANE_SEG_MUL_SAT_EN selects a saturating output with ovf.
module lane_seg_mul_pipe
   import lane_seg_mul_pkg::*;
#(
   parameter int din0_WIDTH = 10,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 21,
   parameter int NUM_STAGE  = 3,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  is_signed,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int P = prod_width(din0_WIDTH, din1_WIDTH);
   localparam int N = NUM_STAGE;

   stage_hdr_t hdr_q [N];
   stage_hdr_t hdr_d [N];

   logic [dout_WIDTH-1:0] dout_q, dout_d, nar_dout;
   logic                  ovf_q, ovf_d, nar_ovf;
   logic [P:0]            a_x, b_x, prod;
   logic [P:0]            nar_in;
   logic                  nar_sgn;
   logic                  en;
   logic                  unused_sgn;

   assign en         = ~hdr_q[N-1].valid | out_ready;
   assign in_ready   = en;
   assign out_valid  = hdr_q[N-1].valid;
   assign dout       = dout_q;
   assign ovf        = ovf_q & hdr_q[N-1].valid;
   assign unused_sgn = hdr_q[N-1].is_signed;

   // extend both operands per the beat's mode and form the product
   always_comb begin
      a_x  = {{(P+1-din0_WIDTH){is_signed & din0[din0_WIDTH-1]}}, din0};
      b_x  = {{(P+1-din1_WIDTH){is_signed & din1[din1_WIDTH-1]}}, din1};
      prod = a_x * b_x;
   end

   if (N == 1) begin : g_one
      assign nar_in  = prod;
      assign nar_sgn = is_signed;
   end else begin : g_mid
      logic [P:0] data_q [N-1];
      logic [P:0] data_d [N-1];

      // shift products through the middle stages on advance
      always_comb begin
         for (int k = 0; k < N - 1; k++) data_d[k] = data_q[k];
         if (en) begin
            data_d[0] = prod;
            for (int k = 1; k < N - 1; k++) data_d[k] = data_q[k-1];
         end
      end

      // middle-stage data registers, cleared on reset
      always_ff @(posedge clk) begin
         for (int k = 0; k < N - 1; k++)
            data_q[k] <= reset ? '0 : data_d[k];
      end

      assign nar_in  = data_q[N-2];
      assign nar_sgn = hdr_q[N-2].is_signed;
   end

   lane_seg_mul_narrow #(
      .PW    (P),
      .DW    (dout_WIDTH),
      .SHIFT (SHIFT),
      .ROUND (ROUND)
   ) u_narrow (
      .is_signed (nar_sgn),
      .prod      (nar_in),
      .dout      (nar_dout),
      .ovf       (nar_ovf)
   );

   // whole pipe advances together or holds together
   always_comb begin
      for (int k = 0; k < N; k++) hdr_d[k] = hdr_q[k];
      dout_d = dout_q;
      ovf_d  = ovf_q;
      if (en) begin
         hdr_d[0].valid     = in_valid;
         hdr_d[0].is_signed = is_signed;
         for (int k = 1; k < N; k++) hdr_d[k] = hdr_q[k-1];
         dout_d = nar_dout;
         ovf_d  = nar_ovf;
      end
   end

   // stage headers and last-stage result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N; k++) hdr_q[k] <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) hdr_q[k] <= hdr_d[k];
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_lane_seg_mul_pipe.sv
// Directed and randomized checks of lane_seg_mul_pipe across four
// configurations sharing one input stream.
module tb_lane_seg_mul_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sv = 1'b0;
   logic        ssg = 1'b0;
   logic        sr = 1'b1;
   logic [9:0]  sa = '0;
   logic [11:0] sb = '0;

   logic [3:0]  ir, ov, of;
   logic [20:0] dd [4];
   logic [20:0] d0, d3;
   logic [17:0] d1, d2;

   int errors = 0;
   int checks = 0;

   int ns [4] = '{3, 1, 2, 5};
   int sh [4] = '{0, 4, 4, 0};
   int rn [4] = '{0, 1, 0, 0};
   int dw [4] = '{21, 18, 18, 21};

   always #5 clk = ~clk;

   assign dd[0] = d0;
   assign dd[1] = {3'b000, d1};
   assign dd[2] = {3'b000, d2};
   assign dd[3] = d3;

   lane_seg_mul_pipe #(.NUM_STAGE(3)) u0 (
      .clk(clk), .reset(reset), .in_valid(sv), .in_ready(ir[0]),
      .is_signed(ssg), .din0(sa), .din1(sb), .out_valid(ov[0]),
      .out_ready(sr), .dout(d0), .ovf(of[0]));

   lane_seg_mul_pipe #(.dout_WIDTH(18), .NUM_STAGE(1), .SHIFT(4),
                       .ROUND(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(sv), .in_ready(ir[1]),
      .is_signed(ssg), .din0(sa), .din1(sb), .out_valid(ov[1]),
      .out_ready(sr), .dout(d1), .ovf(of[1]));

   lane_seg_mul_pipe #(.dout_WIDTH(18), .NUM_STAGE(2), .SHIFT(4),
                       .ROUND(0)) u2 (
      .clk(clk), .reset(reset), .in_valid(sv), .in_ready(ir[2]),
      .is_signed(ssg), .din0(sa), .din1(sb), .out_valid(ov[2]),
      .out_ready(sr), .dout(d2), .ovf(of[2]));

   lane_seg_mul_pipe #(.NUM_STAGE(5)) u3 (
      .clk(clk), .reset(reset), .in_valid(sv), .in_ready(ir[3]),
      .is_signed(ssg), .din0(sa), .din1(sb), .out_valid(ov[3]),
      .out_ready(sr), .dout(d3), .ovf(of[3]));

   function automatic logic [20:0] model(
      input logic [9:0] a, input logic [11:0] b, input logic sg,
      input int s, input int rd, input int w, output logic o);
      longint av, bv, p, r, mx, mn;
      av = sg ? longint'($signed(a)) : longint'(a);
      bv = sg ? longint'($signed(b)) : longint'(b);
      p  = av * bv;
      if (rd != 0 && s > 0) p = p + (longint'(1) << (s - 1));
      r  = p >>> s;
      o  = 1'b0;
`ifdef LANE_SEG_MUL_SAT_EN
      mx = sg ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
      mn = sg ? -(longint'(1) << (w - 1)) : 0;
      if (r > mx) begin r = mx; o = 1'b1; end
      if (r < mn) begin r = mn; o = 1'b1; end
`else
      mx = 0;
      mn = 0;
`endif
      r = r & ((longint'(1) << w) - 1);
      return r[20:0];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      sv = 1'b0;
      sr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ov !== 4'b0000) begin
         errors++;
         $display("FAIL reset_out_valid got %b exp 0000", ov);
      end
      checks++;
      if (ir !== 4'b1111) begin
         errors++;
         $display("FAIL reset_in_ready got %b exp 1111", ir);
      end
      checks++;
      if (dd[0] !== 21'd0 || dd[3] !== 21'd0) begin
         errors++;
         $display("FAIL reset_dout got %0h/%0h exp 0", dd[0], dd[3]);
      end
      checks++;
      if (of !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ovf got %b exp 0000", of);
      end
   endtask

   task automatic test_unsigned();
      logic [20:0] e;
      logic        eo;
`ifdef LANE_SEG_MUL_SAT_EN
      e  = 21'd2097151;
      eo = 1'b1;
`else
      e  = 21'd2092033;
      eo = 1'b0;
`endif
      do_reset();
      @(negedge clk);
      sv = 1'b1; ssg = 1'b0; sa = 10'd1023; sb = 12'd4095;
      @(negedge clk);
      sv = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0) begin
         errors++;
         $display("FAIL unsigned_early got %b exp 0", ov[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b1) begin
         errors++;
         $display("FAIL unsigned_valid got %b exp 1", ov[0]);
      end
      checks++;
      if (dd[0] !== e) begin
         errors++;
         $display("FAIL unsigned_dout got %0d exp %0d", dd[0], e);
      end
      checks++;
      if (of[0] !== eo) begin
         errors++;
         $display("FAIL unsigned_ovf got %b exp %b", of[0], eo);
      end
   endtask

   task automatic test_signed_mixed();
      do_reset();
      @(negedge clk);
      sv = 1'b1; ssg = 1'b1; sa = 10'h3FF; sb = 12'h002;
      @(negedge clk);
      ssg = 1'b0;
      @(negedge clk);
      sv = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b1 || dd[0] !== 21'h1FFFFE) begin
         errors++;
         $display("FAIL signed_dout got v=%b %0h exp v=1 1ffffe",
                  ov[0], dd[0]);
      end
      checks++;
      if (of[0] !== 1'b0) begin
         errors++;
         $display("FAIL signed_ovf got %b exp 0", of[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b1 || dd[0] !== 21'd2046) begin
         errors++;
         $display("FAIL unsigned_bits_dout got v=%b %0d exp v=1 2046",
                  ov[0], dd[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0) begin
         errors++;
         $display("FAIL signed_tail got %b exp 0", ov[0]);
      end
   endtask

   task automatic test_round();
      do_reset();
      @(negedge clk);
      sv = 1'b1; ssg = 1'b0; sa = 10'd5; sb = 12'd3;
      @(posedge clk); #1;
      checks++;
      if (ov[1] !== 1'b1 || dd[1] !== 21'd1) begin
         errors++;
         $display("FAIL round_up got v=%b %0h exp v=1 1", ov[1], dd[1]);
      end
      @(negedge clk);
      ssg = 1'b1; sa = 10'h3F8; sb = 12'd3;
      @(posedge clk); #1;
      checks++;
      if (dd[1] !== 21'h3FFFF) begin
         errors++;
         $display("FAIL round_neg got %0h exp 3ffff", dd[1]);
      end
      checks++;
      if (ov[2] !== 1'b1 || dd[2] !== 21'd0) begin
         errors++;
         $display("FAIL trunc_pos got v=%b %0h exp v=1 0", ov[2], dd[2]);
      end
      @(negedge clk);
      sv = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (dd[2] !== 21'h3FFFE) begin
         errors++;
         $display("FAIL trunc_neg got %0h exp 3fffe", dd[2]);
      end
      checks++;
      if (ov[1] !== 1'b0) begin
         errors++;
         $display("FAIL round_tail got %b exp 0", ov[1]);
      end
   endtask

   task automatic test_latency();
      int lat [4];
      do_reset();
      for (int k = 0; k < 4; k++) lat[k] = 0;
      @(negedge clk);
      sv = 1'b1; ssg = 1'b0; sa = 10'd7; sb = 12'd9;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 4; k++)
            if (ov[k] && lat[k] == 0) lat[k] = c;
         @(negedge clk);
         sv = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (lat[k] != ns[k]) begin
            errors++;
            $display("FAIL latency_%0d got %0d exp %0d", k, lat[k], ns[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int          i, rd;
      logic        hold, eir;
      logic [20:0] hv, e;
      do_reset();
      i = 0; rd = 0; hold = 1'b0; hv = '0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         sr  = !(c >= 5 && c <= 9);
         sv  = (i < 8);
         ssg = 1'b0;
         sa  = 10'(i * 2);
         sb  = 12'(i + 1);
         #1;
         eir = !(c >= 5 && c <= 9);
         if (c <= 12) begin
            checks++;
            if (ir[0] !== eir) begin
               errors++;
               $display("FAIL bp_in_ready c=%0d got %b exp %b",
                        c, ir[0], eir);
            end
         end
         if (hold) begin
            checks++;
            if (ov[0] !== 1'b1 || dd[0] !== hv) begin
               errors++;
               $display("FAIL bp_hold c=%0d got v=%b %0d exp v=1 %0d",
                        c, ov[0], dd[0], hv);
            end
         end
         hold = ov[0] && !sr;
         hv   = dd[0];
         if (ov[0] && sr) begin
            e = 21'(2 * rd * (rd + 1));
            checks++;
            if (dd[0] !== e) begin
               errors++;
               $display("FAIL bp_order n=%0d got %0d exp %0d", rd, dd[0], e);
            end
            rd++;
         end
         if (sv && ir[0]) i++;
      end
      checks++;
      if (rd != 8 || i != 8) begin
         errors++;
         $display("FAIL bp_count got out=%0d in=%0d exp 8/8", rd, i);
      end
   endtask

   task automatic test_reset_midstream();
      logic seen;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         sv = 1'b1; ssg = 1'b0;
         sa = 10'(c + 3); sb = 12'(c + 7);
         reset = (c == 2);
      end
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0 || ov[3] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_valid got %b/%b exp 0/0", ov[0], ov[3]);
      end
      checks++;
      if (ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_ready got %b exp 1", ir[0]);
      end
      checks++;
      if (dd[0] !== 21'd0) begin
         errors++;
         $display("FAIL mid_reset_dout got %0h exp 0", dd[0]);
      end
      @(negedge clk);
      reset = 1'b0;
      sv = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ov[0] || ov[3]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_stale got %b exp 0", seen);
      end
   endtask

   task automatic test_sweep();
      logic [20:0] em [4][64];
      logic        eo [4][64];
      int          wr [4];
      int          rd [4];
      logic        o;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wr[k] = 0;
         rd[k] = 0;
      end
      for (int c = 0; c < 240; c++) begin
         @(negedge clk);
         if (c < 200) begin
            sv  = 1'($urandom_range(0, 1));
            ssg = 1'($urandom_range(0, 1));
            sa  = 10'($urandom);
            sb  = 12'($urandom);
            sr  = ($urandom_range(0, 3) != 0);
         end else begin
            sv = 1'b0;
            sr = 1'b1;
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            if (ov[k] && sr) begin
               checks++;
               if (rd[k] == wr[k]) begin
                  errors++;
                  $display("FAIL sweep_extra_%0d got %0h exp none",
                           k, dd[k]);
               end else begin
                  if (dd[k] !== em[k][rd[k] % 64] ||
                      of[k] !== eo[k][rd[k] % 64]) begin
                     errors++;
                     $display("FAIL sweep_%0d n=%0d got %0h/%b exp %0h/%b",
                              k, rd[k], dd[k], of[k],
                              em[k][rd[k] % 64], eo[k][rd[k] % 64]);
                  end
                  rd[k]++;
               end
            end
            if (sv && ir[k]) begin
               em[k][wr[k] % 64] = model(sa, sb, ssg, sh[k], rn[k], dw[k], o);
               eo[k][wr[k] % 64] = o;
               wr[k]++;
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rd[k] != wr[k] || wr[k] == 0) begin
            errors++;
            $display("FAIL sweep_count_%0d got %0d exp %0d",
                     k, rd[k], wr[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed_mixed();
      test_round();
      test_latency();
      test_backpressure();
      test_reset_midstream();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
